// File: rtl/cond_branch_ctrl.sv
// cond_branch_ctrl
//   Resolves ARM-style conditional B/BL instructions in the ID stage, keeps
//   the registered PSR flags, sequences the post-branch flush window and
//   counts taken and not-taken conditional branches.
//
// Parameters
//   FLUSH_CYCLES  cycles flush is held after a taken branch (0..15)
//   CNT_W         width of each statistics counter (4..32)
//
// Ports
//   clk           rising-edge clock
//   reset_n       synchronous active-low reset
//   cond_code     condition field of the ID-stage instruction
//   B_instr       ID instruction is B
//   BL_instr      ID instruction is BL
//   id_valid      ID instruction valid
//   ex_valid      EX instruction valid
//   ex_s_bit      EX instruction writes flags
//   alu_flags     EX ALU flags {N,Z,C,V}
//   stall         pipeline stall, freezes all state
//   Branch        taken branch resolved this cycle (combinational)
//   BranchL       taken branch is a BL (combinational)
//   flush         squash younger fetched instructions (registered)
//   psr_flags     registered PSR {N,Z,C,V}
//   taken_cnt     saturating count of taken branches
//   not_taken_cnt saturating count of not-taken conditional branches
module cond_branch_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       cond_code,
    input  logic             B_instr,
    input  logic             BL_instr,
    input  logic             id_valid,
    input  logic             ex_valid,
    input  logic             ex_s_bit,
    input  logic [3:0]       alu_flags,
    input  logic             stall,
    output logic             Branch,
    output logic             BranchL,
    output logic             flush,
    output logic [3:0]       psr_flags,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] not_taken_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // The counter is reloaded with FLUSH_CYCLES-1 so that FLUSH is left on
    // the non-stalled cycle where it reads zero.
    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic             flush_q, flush_d;
    logic [3:0]       psr_q, psr_d;
    logic [CNT_W-1:0] taken_q, taken_d;
    logic [CNT_W-1:0] ntaken_q, ntaken_d;

    logic             psr_wr;
    logic [3:0]       eff_flags;
    logic             cond_true;
    logic             br_req;
    logic             branch_w;

    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cc)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c & !z;
            4'b1001: cond_pass = !c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        sat_inc = (x == CNT_MAX) ? x : x + 1'b1;
    endfunction

    // Forward the EX flags so a flag-setting instruction and the branch
    // behind it resolve in the same cycle.
    assign psr_wr    = ex_valid & ex_s_bit;
    assign eff_flags = psr_wr ? alu_flags : psr_q;
    assign cond_true = cond_pass(cond_code, eff_flags);
    assign br_req    = id_valid & (B_instr | BL_instr) & !stall & (state_q == IDLE);
    assign branch_w  = reset_n & br_req & cond_true;

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        flush_d  = flush_q;
        psr_d    = psr_q;
        taken_d  = taken_q;
        ntaken_d = ntaken_q;

        if (psr_wr) begin
            psr_d = alu_flags;
        end

        if (branch_w) begin
            taken_d = sat_inc(taken_q);
        end else if (br_req) begin
            ntaken_d = sat_inc(ntaken_q);
        end

        case (state_q)
            IDLE: begin
                if (branch_w && (FLUSH_CYCLES > 0)) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                    flush_d = 1'b1;
                end
            end
            FLUSH: begin
                if (fcnt_q == 4'd0) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                flush_d = 1'b0;
            end
        endcase
    end

    // Reset wins over stall; otherwise stall freezes every register,
    // including the flush down-counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            fcnt_q   <= 4'd0;
            flush_q  <= 1'b0;
            psr_q    <= 4'd0;
            taken_q  <= '0;
            ntaken_q <= '0;
        end else if (!stall) begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            flush_q  <= flush_d;
            psr_q    <= psr_d;
            taken_q  <= taken_d;
            ntaken_q <= ntaken_d;
        end
    end

    assign Branch        = branch_w;
    assign BranchL       = branch_w & BL_instr;
    assign flush         = flush_q;
    assign psr_flags     = psr_q;
    assign taken_cnt     = taken_q;
    assign not_taken_cnt = ntaken_q;

endmodule

// File: tb/tb_cond_branch_ctrl.sv
// tb_cond_branch_ctrl
//   Drives three differently parameterised copies of cond_branch_ctrl from a
//   shared stimulus: default (FLUSH_CYCLES=1, CNT_W=16), FLUSH_CYCLES=2 with
//   CNT_W=4, and FLUSH_CYCLES=0. A behavioural model tracks each copy and is
//   compared every cycle; directed literal expectations pin the key cases.
module tb_cond_branch_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] cond_code;
    logic       B_instr, BL_instr, id_valid, ex_valid, ex_s_bit, stall;
    logic [3:0] alu_flags;

    logic [2:0]  br_w, brl_w, fl_w;
    logic [3:0]  psr0, psr1, psr2;
    logic [15:0] tk0, nt0, tk2, nt2;
    logic [3:0]  tk1, nt1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cond_branch_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) u0 (
        .clk(clk), .reset_n(reset_n), .cond_code(cond_code), .B_instr(B_instr),
        .BL_instr(BL_instr), .id_valid(id_valid), .ex_valid(ex_valid), .ex_s_bit(ex_s_bit),
        .alu_flags(alu_flags), .stall(stall), .Branch(br_w[0]), .BranchL(brl_w[0]),
        .flush(fl_w[0]), .psr_flags(psr0), .taken_cnt(tk0), .not_taken_cnt(nt0));

    cond_branch_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) u1 (
        .clk(clk), .reset_n(reset_n), .cond_code(cond_code), .B_instr(B_instr),
        .BL_instr(BL_instr), .id_valid(id_valid), .ex_valid(ex_valid), .ex_s_bit(ex_s_bit),
        .alu_flags(alu_flags), .stall(stall), .Branch(br_w[1]), .BranchL(brl_w[1]),
        .flush(fl_w[1]), .psr_flags(psr1), .taken_cnt(tk1), .not_taken_cnt(nt1));

    cond_branch_ctrl #(.FLUSH_CYCLES(0), .CNT_W(16)) u2 (
        .clk(clk), .reset_n(reset_n), .cond_code(cond_code), .B_instr(B_instr),
        .BL_instr(BL_instr), .id_valid(id_valid), .ex_valid(ex_valid), .ex_s_bit(ex_s_bit),
        .alu_flags(alu_flags), .stall(stall), .Branch(br_w[2]), .BranchL(brl_w[2]),
        .flush(fl_w[2]), .psr_flags(psr2), .taken_cnt(tk2), .not_taken_cnt(nt2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    // ARM condition table from the flag meanings.
    function automatic bit cond_holds(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Model: PSR value, remaining flush cycles, and the two counts per copy.
    int         FC[3]   = '{1, 2, 0};
    int         CMAX[3] = '{65535, 15, 65535};
    logic [3:0] m_psr[3];
    int         m_left[3];
    int         m_tk[3];
    int         m_nt[3];
    bit         m_ok = 1'b0;

    always @(negedge clk) begin
        logic [3:0] eff;
        bit         req, hit;
        int         a_tk[3], a_nt[3];
        logic [3:0] a_psr[3];
        a_tk  = '{int'(tk0), int'(tk1), int'(tk2)};
        a_nt  = '{int'(nt0), int'(nt1), int'(nt2)};
        a_psr = '{psr0, psr1, psr2};
        for (int k = 0; k < 3; k++) begin
            eff = (ex_valid && ex_s_bit) ? alu_flags : m_psr[k];
            req = id_valid && (B_instr || BL_instr) && !stall && (m_left[k] == 0);
            hit = req && cond_holds(cond_code, eff);
            if (m_ok) begin
                chk($sformatf("m%0d_Branch", k), 32'(br_w[k]), 32'(reset_n && hit));
                chk($sformatf("m%0d_BranchL", k), 32'(brl_w[k]), 32'(reset_n && hit && BL_instr));
                chk($sformatf("m%0d_flush", k), 32'(fl_w[k]), 32'(m_left[k] > 0));
                chk($sformatf("m%0d_psr", k), 32'(a_psr[k]), 32'(m_psr[k]));
                chk($sformatf("m%0d_taken", k), a_tk[k], m_tk[k]);
                chk($sformatf("m%0d_ntaken", k), a_nt[k], m_nt[k]);
            end
            // Advance to the state after the coming rising edge.
            if (!reset_n) begin
                m_psr[k] = 4'd0; m_left[k] = 0; m_tk[k] = 0; m_nt[k] = 0;
            end else if (!stall) begin
                if (ex_valid && ex_s_bit) m_psr[k] = alu_flags;
                if (m_left[k] > 0) begin
                    m_left[k]--;
                end else if (req) begin
                    if (hit) begin
                        if (m_tk[k] < CMAX[k]) m_tk[k]++;
                        m_left[k] = FC[k];
                    end else if (m_nt[k] < CMAX[k]) begin
                        m_nt[k]++;
                    end
                end
            end
        end
        if (!reset_n) m_ok = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cond_code = 4'd0; B_instr = 0; BL_instr = 0; id_valid = 0;
        ex_valid = 0; ex_s_bit = 0; alu_flags = 4'd0; stall = 0;
    endtask

    task automatic br(input logic [3:0] cc, input logic bl);
        idle();
        cond_code = cc; id_valid = 1'b1;
        B_instr = !bl; BL_instr = bl;
    endtask

    initial begin
        int fcount;
        idle();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_psr", 32'(psr0), 32'h0);
        chk("rst_taken", 32'(tk0), 32'h0);
        chk("rst_ntaken", 32'(nt0), 32'h0);
        chk("rst_flush", 32'(fl_w[0]), 32'h0);
        tick();

        // Flag write forwarded into a same-cycle BEQ.
        br(4'b0000, 1'b0);
        ex_valid = 1'b1; ex_s_bit = 1'b1; alu_flags = 4'b0100;
        @(negedge clk);
        chk("fwd_Branch", 32'(br_w[0]), 32'h1);
        tick();
        idle();
        @(negedge clk);
        chk("fwd_psr", 32'(psr0), 32'h4);
        chk("fwd_taken", 32'(tk0), 32'h1);
        chk("fwd_flush", 32'(fl_w[0]), 32'h1);
        tick();

        // PSR = N only; GE fails, LT taken as BL.
        ex_valid = 1'b1; ex_s_bit = 1'b1; alu_flags = 4'b1000;
        tick();
        idle(); tick();
        br(4'b1010, 1'b1);
        @(negedge clk);
        chk("ge_Branch", 32'(br_w[0]), 32'h0);
        tick();
        br(4'b1011, 1'b1);
        @(negedge clk);
        chk("ge_ntaken", 32'(nt0), 32'h1);
        chk("lt_Branch", 32'(br_w[0]), 32'h1);
        chk("lt_BranchL", 32'(brl_w[0]), 32'h1);
        tick();
        idle(); tick(); tick(); tick();

        // FLUSH_CYCLES=2: branch offered during flush is ignored.
        br(4'b1110, 1'b0);
        tick();
        br(4'b1110, 1'b0);
        @(negedge clk);
        chk("f2_flush_c1", 32'(fl_w[1]), 32'h1);
        chk("f2_ignored", 32'(br_w[1]), 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("f2_flush_c2", 32'(fl_w[1]), 32'h1);
        tick();
        @(negedge clk);
        chk("f2_flush_end", 32'(fl_w[1]), 32'h0);
        tick();

        // Three stalled cycles stretch the two-cycle flush to five.
        br(4'b1110, 1'b0);
        tick();
        fcount = 0;
        for (int i = 0; i < 10; i++) begin
            idle();
            stall = (i >= 1 && i <= 3);
            @(negedge clk);
            if (fl_w[1]) fcount++;
            tick();
        end
        idle();
        chk("f2_stall_len", 32'(fcount), 32'd5);

        // 20 taken branches saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            br(4'b1110, 1'b0); tick();
            idle(); tick(); tick();
        end
        @(negedge clk);
        chk("sat_taken", 32'(tk1), 32'd15);
        tick();

        // FLUSH_CYCLES=0: back-to-back taken branches.
        reset_n = 1'b0; tick();
        reset_n = 1'b1;
        br(4'b1110, 1'b0);
        @(negedge clk);
        chk("f0_br1", 32'(br_w[2]), 32'h1);
        tick();
        @(negedge clk);
        chk("f0_br2", 32'(br_w[2]), 32'h1);
        chk("f0_flush", 32'(fl_w[2]), 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("f0_taken", 32'(tk2), 32'd2);
        chk("f0_flush_after", 32'(fl_w[2]), 32'h0);
        tick();

        // Reset during FLUSH aborts it; Branch forced low in reset.
        br(4'b1110, 1'b0);
        tick();
        br(4'b1110, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rf_in_flush", 32'(fl_w[1]), 32'h1);
        chk("rf_branch_rst", 32'(br_w[2]), 32'h0);
        tick();
        reset_n = 1'b1;
        idle();
        @(negedge clk);
        chk("rf_flush", 32'(fl_w[1]), 32'h0);
        chk("rf_taken", 32'(tk1), 32'h0);
        chk("rf_ntaken", 32'(nt1), 32'h0);
        chk("rf_psr", 32'(psr1), 32'h0);
        tick();
        br(4'b1111, 1'b0);
        @(negedge clk);
        chk("nv_Branch", 32'(br_w[0]), 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("nv_ntaken", 32'(nt0), 32'h1);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
